wb2spi: RTL and testbench
=========================

# wb2spi

Wishbone B4 classic slave that turns single-byte bus cycles into SPI transactions on an external serial SRAM (23LC-style, 24-bit address, mode 0). It sits directly downstream of `uart2wb` and consumes its 23-bit-address, 8-bit-data bus. It is the external-memory alternative to the on-chip `wb2sram`, so host UART reads and writes reach a full serial SRAM. One bus cycle maps to exactly one SPI frame: command, address, data.

## Interface
Parameters:
- `SCK_DIV`, default 2: SCK half-period in `clk_i` cycles; legal values are 1 to 255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe.
- `adr_i` in 23: byte address.
- `dat_i` in 8: write data.
- `we_i` in 1: 1 = write, 0 = read.
- `ack_o` out 1: single-cycle acknowledge.
- `err_o` out 1: tied 0.
- `rty_o` out 1: tied 0.
- `dat_o` out 8: read data, held until the next read completes.
- `spi_sck` out 1: SPI clock, idles low.
- `spi_mosi` out 1: master out.
- `spi_miso` in 1: master in; the board synchronises it externally.
- `spi_ss_n` out 1: chip select, active low.

## Operation
- Reset values: `ack_o`=0, `err_o`=0, `rty_o`=0, `dat_o`=0x00, `spi_sck`=0, `spi_mosi`=0, `spi_ss_n`=1, state IDLE.
- **IDLE**:
  - Accept a request when `cyc_i & stb_i & !ack_o`.
  - On accept, latch a 40-bit frame into the shift register: {cmd, 1'b0, `adr_i`, data}.
  - cmd = 0x02 for a write, 0x03 for a read.
  - data = `dat_i` for a write, 0x00 for a read.
  - Go to SHIFT.
- **SHIFT**:
  - `spi_ss_n`=0 for the whole state.
  - `spi_mosi` always drives the frame MSB.
  - A half-period counter runs from `SCK_DIV`-1 down to 0. At each wrap, SCK toggles.
  - On a rising edge, sample `spi_miso` into the receive register LSB.
  - On a falling edge, shift the frame left and increment the bit counter (6 bits).
  - On the 40th falling edge, go to DONE.
- **DONE**:
  - `spi_ss_n`=1 and `spi_sck`=0.
  - For a read, load `dat_o` with the last 8 sampled bits.
  - Pulse `ack_o` for one cycle, then return to IDLE.
- Mode 0 throughout: the slave samples MOSI on SCK rising, and the block samples MISO on SCK rising.
- `cyc_i` or `stb_i` dropping during SHIFT:
  - The frame completes on SPI, so the SRAM never sees a truncated command.
  - DONE is still entered, but `ack_o` is suppressed if `cyc_i` is low in DONE.
  - `dat_o` still updates on a read.
- `adr_i`, `dat_i` and `we_i` are sampled only at accept; later changes have no effect.
- Reset mid-frame: `spi_ss_n` goes high and `spi_sck` goes low immediately (asynchronously). The SRAM discards the partial frame.

## Timing
- Accept edge E0: `spi_ss_n` falls, and MOSI carries bit 39 (cmd MSB).
- The k-th SCK rising edge (k = 1..40) occurs at E0 + (2k−1)·`SCK_DIV`.
- The k-th SCK falling edge occurs at E0 + 2k·`SCK_DIV`.
- `spi_ss_n` rises at E0 + 80·`SCK_DIV`.
- `ack_o` is high in the cycle following E0 + 80·`SCK_DIV`, i.e. latency is 80·`SCK_DIV` + 1 cycles from accept.
- `dat_o` is valid in the same cycle as `ack_o`.
- The earliest next accept is 2 cycles after `spi_ss_n` rises. This guarantees chip select is high for at least 2 `clk_i` cycles between frames.
- There is no pipelining: one outstanding transaction at a time.

## Structure
- Shared package `spi_sram_pkg`:
  - `CMD_READ`=8'h03 and `CMD_WRITE`=8'h02.
  - `FRAME_BITS`=40.
  - State enum {IDLE, SHIFT, DONE}.
- One natural sub-module, `spi_clkgen`: half-period counter plus SCK toggle. It emits one-cycle `rise` and `fall` strobes and is enabled only in SHIFT.
- The shift and receive registers stay in `wb2spi`.

## Test plan
- Write, `SCK_DIV`=1, `adr_i`=0x012345, `dat_i`=0x5A:
  - MOSI bytes are 0x02, 0x01, 0x23, 0x45, 0x5A.
  - `ack_o` goes high exactly 81 cycles after accept, for 1 cycle.
  - `spi_ss_n` is low for exactly 80 cycles.
- Read, `adr_i`=0x7FFFFF, SRAM model returns 0xC3:
  - MOSI is 0x03, 0x7F, 0xFF, 0xFF.
  - `dat_o`=0xC3 with `ack_o`.
  - `dat_o` holds 0xC3 through a subsequent write.
- `SCK_DIV`=3: every SCK high and low phase measures 3 cycles, and `ack_o` arrives 241 cycles after accept.
- `cyc_i` dropped at bit 10:
  - The frame still runs 40 bits.
  - No `ack_o`.
  - The next request is accepted normally.
- `rst_i` asserted at bit 20 of a write:
  - `spi_ss_n`=1, `spi_sck`=0 and `ack_o`=0 immediately.
  - After release, a fresh read returns the model's pre-write value.
- Back-to-back: master re-asserts `stb_i` in the cycle after `ack_o`. Required response: `spi_ss_n` stays high for at least 2 cycles, and both transactions complete with correct data.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the Wishbone-to-serial-SRAM bridge.
// Frame layout is {cmd, 1'b0, 23-bit address, data byte}, sent MSB first.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         FRAME_BITS = 40;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       we,
                                                        input logic [22:0] adr,
                                                        input logic [7:0]  dat);
    return {(we ? CMD_WRITE : CMD_READ), 1'b0, adr, (we ? dat : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK generator: toggles every SCK_DIV enabled cycles, first toggle SCK_DIV cycles after enable.
// Emits one-cycle rise/fall strobes in the cycle before SCK changes; disabled means SCK low.
module spi_clkgen #(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] RELOAD = 8'(SCK_DIV - 1);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap = en && (cnt == 8'd0);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= RELOAD;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= RELOAD;
      sck <= !sck;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/wb2spi.sv
// Wishbone classic slave mapping each single-byte cycle onto one mode-0 SPI SRAM frame.
// Latency 80*SCK_DIV+1 cycles from accept; one transaction in flight, no new accept while busy.
module wb2spi
  import spi_sram_pkg::*;
#(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [22:0] adr_i,
  input  logic [7:0]  dat_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic [7:0]  dat_o,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ss_n
);

  state_t                  state, nxt;
  logic [FRAME_BITS-1:0]   frame;
  logic [7:0]              rx;
  logic [5:0]              bit_cnt;
  logic                    is_rd;
  logic                    accept;
  logic                    last_fall;
  logic                    rise, fall;

  assign err_o    = 1'b0;
  assign rty_o    = 1'b0;
  assign spi_mosi = frame[FRAME_BITS-1];

  assign accept    = (state == IDLE) && cyc_i && stb_i && !ack_o;
  assign last_fall = fall && (bit_cnt == 6'(FRAME_BITS - 1));

  spi_clkgen #(.SCK_DIV(SCK_DIV)) u_clkgen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (state == SHIFT),
    .sck   (spi_sck),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SHIFT;
      SHIFT:   if (last_fall) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      frame    <= '0;
      rx       <= 8'h00;
      bit_cnt  <= 6'd0;
      is_rd    <= 1'b0;
      spi_ss_n <= 1'b1;
      ack_o    <= 1'b0;
      dat_o    <= 8'h00;
    end else begin
      state <= nxt;
      // A master that abandoned the cycle mid-frame gets no acknowledge.
      ack_o <= (state == DONE) && cyc_i;
      if (accept) begin
        frame    <= build_frame(we_i, adr_i, dat_i);
        bit_cnt  <= 6'd0;
        is_rd    <= !we_i;
        spi_ss_n <= 1'b0;
      end
      if (state == SHIFT) begin
        if (rise) rx <= {rx[6:0], spi_miso};
        if (fall) begin
          frame   <= {frame[FRAME_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
        if (last_fall) spi_ss_n <= 1'b1;
      end
      if ((state == DONE) && is_rd) dat_o <= rx;
    end
  end

endmodule

// File: tb/tb_wb2spi.sv
// Directed bench for wb2spi with a behavioural 23LC-style SRAM on the SCK_DIV=1 instance.
// A second instance with SCK_DIV=3 is used for phase-length and latency timing.
module tb_wb2spi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [22:0] adr = '0;
  logic [7:0]  wdat = 8'h00;
  logic        ack1, err1, rty1, sck1, mosi1, ss1_n;
  logic        miso1 = 1'b0;
  logic [7:0]  rdat1;
  logic        cyc3 = 1'b0, stb3 = 1'b0;
  logic        ack3, err3, rty3, sck3, mosi3, ss3_n;
  logic        miso3 = 1'b0;
  logic [7:0]  rdat3;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb2spi #(.SCK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .dat_i(wdat),
    .we_i(we), .ack_o(ack1), .err_o(err1), .rty_o(rty1), .dat_o(rdat1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_ss_n(ss1_n)
  );

  wb2spi #(.SCK_DIV(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .adr_i(adr), .dat_i(wdat),
    .we_i(we), .ack_o(ack3), .err_o(err3), .rty_o(rty3), .dat_o(rdat3),
    .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso3), .spi_ss_n(ss3_n)
  );

  // Behavioural serial SRAM: captures MOSI on SCK rise, drives MISO on SCK fall.
  logic [39:0] cap = '0;
  int          bcnt = 0;
  logic [7:0]  mem [logic [22:0]];
  logic [7:0]  rbyte = 8'h00;
  logic        rd_cmd = 1'b0;

  always @(negedge ss1_n) begin
    bcnt = 0;
    cap  = '0;
  end

  always @(posedge sck1) begin
    if (!ss1_n) begin
      cap  = {cap[38:0], mosi1};
      bcnt = bcnt + 1;
    end
  end

  always @(negedge sck1) begin
    if (!ss1_n) begin
      if (bcnt == 32) begin
        rd_cmd = (cap[31:24] == 8'h03);
        rbyte  = mem.exists(cap[22:0]) ? mem[cap[22:0]] : 8'h00;
      end
      if (rd_cmd && bcnt >= 32 && bcnt < 40) miso1 = rbyte[39 - bcnt];
    end
  end

  always @(posedge ss1_n) begin
    if (bcnt == 40 && cap[39:32] == 8'h02) mem[cap[30:8]] = cap[7:0];
  end

  // Chip-select high time before each frame, in clk cycles.
  int hi_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (ss1_n) hi_run = hi_run + 1;
    else hi_run = 0;
  end
  always @(negedge ss1_n) last_gap = hi_run;

  // Caller sits #1 after a posedge; returns accept-to-ack latency and ss_n low cycles.
  task automatic xfer(input logic w, input logic [22:0] a, input logic [7:0] d,
                      output int lat, output int low, output logic ack_after,
                      output logic [7:0] rd);
    int n;
    n   = 0;
    low = 0;
    lat = -1;
    rd  = 8'hxx;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      n++;
      if (!ss1_n) low++;
      if (ack1) begin
        lat = n - 1;
        rd  = rdat1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    ack_after = ack1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (ack1 !== 1'b0)    begin errs++; $display("FAIL reset_ack got %b want 0", ack1); end
    vecs++; if (err1 !== 1'b0)    begin errs++; $display("FAIL reset_err got %b want 0", err1); end
    vecs++; if (rty1 !== 1'b0)    begin errs++; $display("FAIL reset_rty got %b want 0", rty1); end
    vecs++; if (rdat1 !== 8'h00)  begin errs++; $display("FAIL reset_dat got %h want 00", rdat1); end
    vecs++; if (sck1 !== 1'b0)    begin errs++; $display("FAIL reset_sck got %b want 0", sck1); end
    vecs++; if (mosi1 !== 1'b0)   begin errs++; $display("FAIL reset_mosi got %b want 0", mosi1); end
    vecs++; if (ss1_n !== 1'b1)   begin errs++; $display("FAIL reset_ss_n got %b want 1", ss1_n); end
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (ss1_n !== 1'b1 || ack1 !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset got ss_n=%b ack=%b want 1/0", ss1_n, ack1);
    end
  endtask

  task automatic test_write();
    int lat, low; logic aa; logic [7:0] rd;
    xfer(1'b1, 23'h012345, 8'h5A, lat, low, aa, rd);
    vecs++; if (cap !== 40'h0201_2345_5A) begin errs++; $display("FAIL wr_mosi got %h want 020123455a", cap); end
    vecs++; if (bcnt !== 40) begin errs++; $display("FAIL wr_bits got %0d want 40", bcnt); end
    vecs++; if (lat !== 81)  begin errs++; $display("FAIL wr_latency got %0d want 81", lat); end
    vecs++; if (low !== 80)  begin errs++; $display("FAIL wr_ss_low got %0d want 80", low); end
    vecs++; if (aa !== 1'b0) begin errs++; $display("FAIL wr_ack_width got %b want 0", aa); end
    vecs++; if (mem[23'h012345] !== 8'h5A) begin
      errs++; $display("FAIL wr_sram got %h want 5a", mem[23'h012345]);
    end
  endtask

  task automatic test_read();
    int lat, low; logic aa; logic [7:0] rd;
    mem[23'h7FFFFF] = 8'hC3;
    xfer(1'b0, 23'h7FFFFF, 8'hEE, lat, low, aa, rd);
    vecs++; if (cap[39:8] !== 32'h037F_FFFF) begin errs++; $display("FAIL rd_mosi got %h want 037fffff", cap[39:8]); end
    vecs++; if (rd !== 8'hC3) begin errs++; $display("FAIL rd_data got %h want c3", rd); end
    vecs++; if (lat !== 81)   begin errs++; $display("FAIL rd_latency got %0d want 81", lat); end
    xfer(1'b1, 23'h000010, 8'h3C, lat, low, aa, rd);
    vecs++; if (rdat1 !== 8'hC3) begin errs++; $display("FAIL rd_hold got %h want c3", rdat1); end
  endtask

  task automatic test_div3();
    int n, run, toggles, bad, lat;
    logic prev;
    n = 0; run = 0; toggles = 0; bad = 0; lat = -1; prev = 1'b0;
    cyc3 = 1'b1; stb3 = 1'b1; we = 1'b1; adr = 23'h000042; wdat = 8'h81;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      n++;
      if (ack3) begin lat = n - 1; break; end
      if (sck3 !== prev) begin
        if (run != 3) bad++;
        toggles++;
        run  = 1;
        prev = sck3;
      end else begin
        run++;
      end
    end
    cyc3 = 1'b0; stb3 = 1'b0;
    @(posedge clk); #1;
    vecs++; if (bad !== 0)      begin errs++; $display("FAIL div3_phase got %0d bad phases want 0", bad); end
    vecs++; if (toggles !== 80) begin errs++; $display("FAIL div3_toggles got %0d want 80", toggles); end
    vecs++; if (lat !== 241)    begin errs++; $display("FAIL div3_latency got %0d want 241", lat); end
  endtask

  task automatic test_cyc_drop();
    int lat, low; logic aa; logic [7:0] rd; logic saw_ack;
    saw_ack = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 23'h000100; wdat = 8'h77;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (bcnt >= 10 && !ss1_n) break;
    end
    vecs++; if (bcnt !== 10) begin errs++; $display("FAIL drop_reach_bit10 got %0d want 10", bcnt); end
    cyc = 1'b0; stb = 1'b0; adr = 23'h000555; wdat = 8'h00; we = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (ack1) saw_ack = 1'b1;
    end
    vecs++; if (bcnt !== 40)     begin errs++; $display("FAIL drop_bits got %0d want 40", bcnt); end
    vecs++; if (saw_ack !== 1'b0) begin errs++; $display("FAIL drop_no_ack got %b want 0", saw_ack); end
    xfer(1'b0, 23'h000100, 8'h00, lat, low, aa, rd);
    vecs++; if (rd !== 8'h77 || lat !== 81) begin
      errs++; $display("FAIL drop_next got data=%h lat=%0d want 77/81", rd, lat);
    end
  endtask

  task automatic test_mid_reset();
    int lat, low; logic aa; logic [7:0] rd;
    mem[23'h000200] = 8'h11;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 23'h000200; wdat = 8'h99;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (bcnt >= 20 && !ss1_n) break;
    end
    #2 rst = 1'b1;
    #1;
    vecs++; if (ss1_n !== 1'b1 || sck1 !== 1'b0 || ack1 !== 1'b0) begin
      errs++; $display("FAIL midrst_outputs got ss_n=%b sck=%b ack=%b want 1/0/0", ss1_n, sck1, ack1);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 23'h000200, 8'h00, lat, low, aa, rd);
    vecs++; if (rd !== 8'h11) begin errs++; $display("FAIL midrst_read got %h want 11", rd); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, low; logic aa; logic [7:0] rd;
    xfer(1'b1, 23'h000005, 8'hA5, lat1, low, aa, rd);
    xfer(1'b0, 23'h000005, 8'h00, lat2, low, aa, rd);
    vecs++; if (last_gap < 2) begin errs++; $display("FAIL b2b_ss_gap got %0d want >=2", last_gap); end
    vecs++; if (lat1 !== 81 || lat2 !== 81) begin
      errs++; $display("FAIL b2b_latency got %0d/%0d want 81/81", lat1, lat2);
    end
    vecs++; if (rd !== 8'hA5) begin errs++; $display("FAIL b2b_data got %h want a5", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_div3();
    test_cyc_drop();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
